mc_datapath_regs: RTL
=====================

# mc_datapath_regs

Sequential datapath register stage of the multicycle MIPS core. It sits directly downstream of the main control decoder and consumes its control word: PC, instruction register, the non-architectural A/B/ALUOut/MDR latches, PC next-value selection, memory address selection and register-file write muxing. It feeds `op`/`funct` back to the decoder and carries cycle and retired-instruction counters for bring-up.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CNT_W`, 32, width of the performance counters
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; clock `clk`
- `pcwrite`, `branch`, `IorD`, `IRwrite`, `regdst`, `memtoreg`  in  1 each  control from main decoder
- `pcsrc`  in  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target, 11 reserved
- `zero`  in  1  ALU zero flag
- `aluresult`  in  32  combinational ALU output
- `memrdata`  in  32  memory read data, combinational from `memaddr`
- `rd1`, `rd2`  in  32 each  register-file read ports
- `pc`  out  32  current PC register
- `memaddr`  out  32  `IorD ? aluout : pc`
- `instr`  out  32  instruction register
- `op`, `funct`  out  6 each  `instr[31:26]`, `instr[5:0]`
- `a`, `b`, `aluout`, `mdr`  out  32 each  datapath latches
- `writereg`  out  5  `regdst ? instr[15:11] : instr[20:16]`
- `writedata`  out  32  `memtoreg ? mdr : aluout`
- `pcen`  out  1  PC write enable actually applied this cycle
- `cycle_count`, `instr_count`  out  `CNT_W` each  performance counters

## Operation
- `pcen = pcwrite | (branch & zero)`, but forced 0 when `pcsrc == 11`.
- Next PC: 00 -> `aluresult`; 01 -> `aluout`; 10 -> `{pc[31:28], instr[25:0], 2'b00}`, built from the current register values, so `pc` is the already-incremented PC.
- `instr` loads `memrdata` when `IRwrite`; otherwise holds.
- `mdr`, `a`, `b` and `aluout` load unconditionally every cycle from `memrdata`, `rd1`, `rd2` and `aluresult`.
- `cycle_count` increments every non-reset cycle and wraps at 2^CNT_W.
- `instr_count` increments on every cycle with `IRwrite` = 1 (one per fetch) and wraps.
- Combinational outputs (`memaddr`, `writereg`, `writedata`, `op`, `funct`, `pcen`) follow their inputs in the same cycle, including during reset.
- Branch not taken (`branch` = 1, `zero` = 0, `pcwrite` = 0): PC holds.
- `pcwrite` and `branch` both 1: PC is written, because `pcwrite` dominates.

## Timing
- Reset (`reset` = 0 at a rising edge) loads `pc` = `RESET_PC` and clears `instr`, `a`, `b`, `aluout`, `mdr`, `cycle_count` and `instr_count` to 0. Reset wins over every control input in the same cycle.
- Reset asserted mid-instruction: all state is discarded at that edge. The first cycle after release is a fetch from `RESET_PC`, with the decoder reset alongside.
- Fetch cycle (`IRwrite` = `pcwrite` = 1, `IorD` = 0, `pcsrc` = 00): at one edge, `instr` takes `mem[pc]` and `pc` takes `aluresult` (PC+4). Both sample pre-edge values; there is no ordering hazard.
- Latency: any register reflects its input one edge later. `aluout` from cycle N is available to `memaddr`, `writedata` and `pcsrc` = 01 in cycle N+1.
- Load: `mdr` captures data in the MemRead cycle, and `writedata` presents it in the following WriteBack cycle.
- PC increment and jump-target concatenation are modulo 2^32 with no overflow flag.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0040: hold `reset` = 0 for 2 cycles, with arbitrary controls driven -> `pc` = 0x40, all latches and counters 0. Release, then drive `IorD` = 0 -> `memaddr` = 0x40.
- Fetch with `memrdata` = 32'h2008_0005, `aluresult` = 0x44, `IRwrite` = `pcwrite` = 1 -> after the edge, `instr` = 0x2008_0005, `op` = 6'h08, `pc` = 0x44, `instr_count` = 1.
- BEQ: `aluout` = 0x80 from the decode cycle, then `branch` = 1, `pcsrc` = 01, `zero` = 1 -> `pc` = 0x80. Repeat with `zero` = 0 -> `pc` unchanged, `pcen` = 0.
- Jump: `pc` = 0x1000_0008, `instr` = 32'h0800_0010, `pcsrc` = 10, `pcwrite` = 1 -> `pc` = 0x1000_0040.
- Load writeback: `aluout` = 0x100, `IorD` = 1 -> `memaddr` = 0x100. With `memrdata` = 0xDEAD_BEEF, next cycle `memtoreg` = 1, `regdst` = 0, `instr[20:16]` = 9 -> `writedata` = 0xDEAD_BEEF, `writereg` = 9.
- Reserved `pcsrc` = 11 with `pcwrite` = 1 -> `pc` holds, `pcen` = 0.
- Counter wrap with `CNT_W` = 4: 17 non-reset cycles -> `cycle_count` = 1.
- Reset asserted during a MemRead cycle -> next cycle `pc` = `RESET_PC` and counters are 0.

Source files
------------

// File: rtl/mc_datapath_regs.sv
// mc_datapath_regs
// ----------------
// Sequential datapath register stage of the multicycle MIPS core. It holds the
// PC, the instruction register and the non-architectural A/B/ALUOut/MDR
// latches. It also selects the next PC and the memory address, muxes the
// register-file write port, and keeps bring-up cycle/retired-instruction
// counters.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   CNT_W        width of the performance counters
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-low reset
//   pcwrite      unconditional PC write request (main decoder)
//   branch       conditional PC write request, qualified by zero
//   IorD         memory address select: 0 = pc, 1 = aluout
//   IRwrite      load the instruction register from memrdata
//   regdst       write register select: 0 = rt, 1 = rd
//   memtoreg     write data select: 0 = aluout, 1 = mdr
//   pcsrc        next PC select: 00 ALU result, 01 ALUOut, 10 jump, 11 reserved
//   zero         ALU zero flag
//   aluresult    combinational ALU output
//   memrdata     memory read data (combinational from memaddr)
//   rd1, rd2     register-file read data
//   pc           current PC register
//   memaddr      memory address
//   instr        instruction register
//   op, funct    opcode and function fields, fed back to the decoder
//   a, b         register-file read latches
//   aluout       ALU result latch
//   mdr          memory data latch
//   writereg     register-file write address
//   writedata    register-file write data
//   pcen         PC write enable applied this cycle
//   cycle_count  non-reset cycles seen, wraps
//   instr_count  instruction fetches seen, wraps
//
// There are no handshakes here: every control input is a level that is
// sampled at the rising edge, and every output is either a register or a pure
// function of the current registers and inputs.

module mc_datapath_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic             IorD,
  input  logic             IRwrite,
  input  logic             regdst,
  input  logic             memtoreg,
  input  logic [1:0]       pcsrc,
  input  logic             zero,
  input  logic [31:0]      aluresult,
  input  logic [31:0]      memrdata,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  output logic [31:0]      pc,
  output logic [31:0]      memaddr,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic [31:0]      aluout,
  output logic [31:0]      mdr,
  output logic [4:0]       writereg,
  output logic [31:0]      writedata,
  output logic             pcen,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  logic [31:0] pc_next;

  // The reserved select suppresses the write entirely. It must not load an
  // undefined value, so the PC simply holds.
  always_comb begin
    pcen = (pcsrc != 2'b11) && (pcwrite || (branch && zero));
  end

  // The jump target uses the current pc. After a fetch, pc already holds
  // PC+4, so its upper nibble is the one the jump region is based on.
  always_comb begin
    pc_next = pc;
    case (pcsrc)
      2'b00:   pc_next = aluresult;
      2'b01:   pc_next = aluout;
      2'b10:   pc_next = {pc[31:28], instr[25:0], 2'b00};
      default: pc_next = pc;
    endcase
  end

  always_comb begin
    memaddr   = IorD ? aluout : pc;
    op        = instr[31:26];
    funct     = instr[5:0];
    writereg  = regdst ? instr[15:11] : instr[20:16];
    writedata = memtoreg ? mdr : aluout;
  end

  // The latches between the multicycle steps load every cycle. Each step
  // only consumes the value that was captured during the step before it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      a           <= '0;
      b           <= '0;
      aluout      <= '0;
      mdr         <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (pcen) begin
        pc <= pc_next;
      end
      if (IRwrite) begin
        instr       <= memrdata;
        instr_count <= instr_count + CNT_W'(1);
      end
      a           <= rd1;
      b           <= rd2;
      aluout      <= aluresult;
      mdr         <= memrdata;
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule
